dcache_port_arbiter: RTL and testbench
======================================

// Module: dcache_port_arbiter
// PURPOSE
//  Shares the single CPU-Core->DCache IO port (8080-derived valid/ready/error protocol) between NUM_REQ
//  requesters (e.g. LSU, page-table walker, debug). Round-robin grant; one transaction in flight;
//  forwards abort (valid dropped before ready) transparently. Sits between the core-side masters and DCache slave.
// PARAMETERS
//  NUM_REQ       2    number of upstream requesters (2..8)
//  ADDR_W        40   address width
//  DATA_W        64   read/write data width
//  TIMEOUT_CYC   256  watchdog limit in cycles (used only with DCACHE_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1               system clock, all logic on rising edge
//  rst          in   1               synchronous reset, active-high
//  m_valid      in   NUM_REQ         per-requester taskValid
//  m_address    in   NUM_REQ*ADDR_W  per-requester address
//  m_rwCtrl     in   NUM_REQ         0 read / 1 write
//  m_widthCtr   in   NUM_REQ*2       0:1B 1:2B 2:4B 3:8B
//  m_writeBus   in   NUM_REQ*DATA_W  write data
//  m_readBus    out  DATA_W          read data, broadcast; valid only with own m_ready
//  m_ready      out  NUM_REQ         per-requester taskReady
//  m_error      out  NUM_REQ         per-requester taskError
//  s_valid      out  1               downstream taskValid
//  s_address    out  ADDR_W          downstream address
//  s_rwCtrl     out  1               downstream rwCtrl
//  s_widthCtr   out  2               downstream widthCtr
//  s_writeBus   out  DATA_W          downstream writeBus
//  s_readBus    in   DATA_W          downstream read data
//  s_ready      in   1               downstream taskReady
//  s_error      in   1               downstream taskError
// BEHAVIOUR
//  - Reset: state=IDLE, grant=0, rr_ptr=0 (requester 0 highest priority first), all m_ready/m_error=0, s_valid=0.
//  - FSM IDLE: if any m_valid, pick first set bit starting at rr_ptr (wrapping), register grant, go BUSY. No request: stay.
//  - FSM BUSY: s_valid = m_valid[grant] (combinational); s_address/rwCtrl/widthCtr/writeBus muxed from grant.
//    m_ready[grant]=s_ready, m_error[grant]=s_ready&s_error; all other m_ready/m_error=0. m_readBus=s_readBus.
//  - Completion: s_ready=1 in BUSY -> next state IDLE, rr_ptr=(grant+1) mod NUM_REQ. Grant latency 1 cycle from
//    m_valid; one IDLE cycle between back-to-back transactions (s_valid low >=1 cycle between tasks).
//  - Abort: m_valid[grant]=0 while BUSY and s_ready=0 -> s_valid drops same cycle, next state IDLE, rr_ptr advances;
//    slave undoes partial write. m_valid[grant]=0 and s_ready=1 same cycle: completion (ready still reported).
//  - Non-granted requesters keep m_valid high and wait; never see ready. Requests arriving during BUSY are held off.
//  - Requester changing address/ctrl while granted is a protocol violation; arbiter passes it through unchecked.
//  - s_ready/s_error while IDLE ignored (no m_ready generated).
//  - Reset mid-transaction: IDLE next cycle, s_valid=0; downstream sees it as abort.
// CONFIGURATION
//  DCACHE_ARB_TIMEOUT_EN defined: counter clears on grant, increments each BUSY cycle; reaching TIMEOUT_CYC-1 with
//    s_ready=0 -> that cycle m_ready[grant]=1, m_error[grant]=1, s_valid forced 0, next state IDLE (abort downstream).
//    Counter width $clog2(TIMEOUT_CYC). s_ready arriving in the timeout cycle wins (normal completion).
//  Not defined: no counter; BUSY waits indefinitely for s_ready or abort.
// STRUCTURE
//  - Package dcache_arb_pkg: ADDR_W/DATA_W localparams, width_e enum (W8,W16,W32,W64), arb_state_e (IDLE,BUSY).
//  - Sub-module rr_picker #(N): inputs req[N], ptr; outputs gnt_idx, any_req; combinational rotate-priority-encode.
//  - Top: FSM, grant/rr_ptr regs, output muxes, optional watchdog.
// TESTING
//  1 Single read: m_valid[0]=1, addr=0x00_1000_0000, w=3; s_ready after 3 cyc with s_readBus=0xDEADBEEF_CAFEF00D
//    -> s_valid rises 1 cycle after m_valid, m_ready[0]=1 with that data, m_ready[1]=0, s_valid low next cycle.
//  2 Contention: m_valid[0]=m_valid[1]=1 held, slave ready after 1 cyc -> grants 0,1,0,1; each gap exactly 1 IDLE cycle.
//  3 Error: write granted to req1, slave s_ready=1,s_error=1 -> m_ready[1]=1,m_error[1]=1 same cycle, req0 unaffected.
//  4 Abort: req0 granted, drops m_valid after 2 BUSY cycles -> s_valid=0 same cycle, no m_ready, pending req1 granted
//    next IDLE cycle.
//  5 Reset while BUSY: rst=1 one cycle -> s_valid=0, m_ready=0 next cycle, first grant after release goes to req0.
//  6 DCACHE_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, slave silent -> m_ready[g]=m_error[g]=1 at BUSY cycle 16, s_valid=0.

Source files
------------

// File: rtl/dcache_arb_pkg.sv
// Shared types for the DCache port arbiter: default widths, access width
// encoding, FSM states and a round-robin index helper.
package dcache_arb_pkg;

    localparam int ADDR_W = 40;
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        W8  = 2'd0,
        W16 = 2'd1,
        W32 = 2'd2,
        W64 = 2'd3
    } width_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/dcache_port_arbiter_rr_picker.sv
// Rotating-priority encoder: returns the first asserted request at or
// after the pointer position, wrapping around.
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_any_req
);

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        o_gnt_idx = '0;
        o_any_req = |i_req;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % N]) begin
                o_gnt_idx = IW'((int'(i_ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing one DCache valid/ready/error port among
// NUM_REQ masters. Optional watchdog: define DCACHE_ARB_TIMEOUT_EN.
module dcache_port_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = dcache_arb_pkg::ADDR_W,
    parameter int DATA_W      = dcache_arb_pkg::DATA_W,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        m_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] m_address,
    input  logic [NUM_REQ-1:0]        m_rwCtrl,
    input  logic [NUM_REQ*2-1:0]      m_widthCtr,
    input  logic [NUM_REQ*DATA_W-1:0] m_writeBus,
    output logic [DATA_W-1:0]         m_readBus,
    output logic [NUM_REQ-1:0]        m_ready,
    output logic [NUM_REQ-1:0]        m_error,
    output logic                      s_valid,
    output logic [ADDR_W-1:0]         s_address,
    output logic                      s_rwCtrl,
    output logic [1:0]                s_widthCtr,
    output logic [DATA_W-1:0]         s_writeBus,
    input  logic [DATA_W-1:0]         s_readBus,
    input  logic                      s_ready,
    input  logic                      s_error
);

    import dcache_arb_pkg::*;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e    r_state;
    arb_state_e    w_state_nxt;
    logic [IW-1:0] r_grant;
    logic [IW-1:0] w_grant_nxt;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_nxt;
    logic [IW-1:0] w_pick;
    logic [IW-1:0] w_adv;
    logic          w_any;
    logic          w_gvalid;
    logic          w_expire;
    width_e        w_width;

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .i_req     (m_valid),
        .i_ptr     (r_ptr),
        .o_gnt_idx (w_pick),
        .o_any_req (w_any)
    );

    assign w_adv    = IW'(rr_next(int'(r_grant), NUM_REQ));
    assign w_gvalid = m_valid[r_grant];

    assign s_address  = m_address[int'(r_grant)*ADDR_W +: ADDR_W];
    assign s_rwCtrl   = m_rwCtrl[r_grant];
    assign w_width    = width_e'(m_widthCtr[int'(r_grant)*2 +: 2]);
    assign s_widthCtr = w_width;
    assign s_writeBus = m_writeBus[int'(r_grant)*DATA_W +: DATA_W];
    assign m_readBus  = s_readBus;

`ifdef DCACHE_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] r_cnt;

    // Held at zero while idle, so the first BUSY cycle counts as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_expire = (r_state == BUSY) &&
                      (r_cnt == CW'(TIMEOUT_CYC - 1));
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        s_valid     = 1'b0;
        m_ready     = '0;
        m_error     = '0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = BUSY;
                    w_grant_nxt = w_pick;
                end
            end
            BUSY: begin
                s_valid          = w_gvalid;
                m_ready[r_grant] = s_ready;
                m_error[r_grant] = s_ready & s_error;
                // Completion beats abort, abort beats the watchdog.
                if (s_ready || !w_gvalid) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = w_adv;
                end else if (w_expire) begin
                    s_valid          = 1'b0;
                    m_ready[r_grant] = 1'b1;
                    m_error[r_grant] = 1'b1;
                    w_state_nxt      = IDLE;
                    w_ptr_nxt        = w_adv;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter with a transaction-level model
// compared every cycle plus literal checks per scenario.
module tb_dcache_port_arbiter;

    localparam int TO = 16;
`ifdef DCACHE_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [39:0] A0 = 40'h00_1000_0000;
    localparam logic [39:0] A1 = 40'h00_2000_0040;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   m_valid;
    logic [79:0]  m_address;
    logic [1:0]   m_rwCtrl;
    logic [3:0]   m_widthCtr;
    logic [127:0] m_writeBus;
    logic [63:0]  m_readBus;
    logic [1:0]   m_ready;
    logic [1:0]   m_error;
    logic         s_valid;
    logic [39:0]  s_address;
    logic         s_rwCtrl;
    logic [1:0]   s_widthCtr;
    logic [63:0]  s_writeBus;
    logic [63:0]  s_readBus;
    logic         s_ready;
    logic         s_error;

    int nvec = 0;
    int nerr = 0;

    dcache_port_arbiter #(
        .NUM_REQ     (2),
        .ADDR_W      (40),
        .DATA_W      (64),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m_valid    (m_valid),
        .m_address  (m_address),
        .m_rwCtrl   (m_rwCtrl),
        .m_widthCtr (m_widthCtr),
        .m_writeBus (m_writeBus),
        .m_readBus  (m_readBus),
        .m_ready    (m_ready),
        .m_error    (m_error),
        .s_valid    (s_valid),
        .s_address  (s_address),
        .s_rwCtrl   (s_rwCtrl),
        .s_widthCtr (s_widthCtr),
        .s_writeBus (s_writeBus),
        .s_readBus  (s_readBus),
        .s_ready    (s_ready),
        .s_error    (s_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setreq(input int r, input logic [39:0] a,
                          input logic rw, input logic [1:0] w,
                          input logic [63:0] d);
        m_address[r*40 +: 40]  = a;
        m_rwCtrl[r]            = rw;
        m_widthCtr[r*2 +: 2]   = w;
        m_writeBus[r*64 +: 64] = d;
    endtask

    // Transaction-level model: who owns the port, whose turn is next.
    bit mk    = 1'b0;
    bit mbusy = 1'b0;
    int mown  = 0;
    int mptr  = 0;
    int mcnt  = 0;

    always @(negedge clk) begin
        logic [1:0] er;
        logic [1:0] ee;
        logic       ev;
        bit         to;
        er = '0;
        ee = '0;
        ev = 1'b0;
        to = 1'b0;
        if (mk) begin
            if (mbusy) begin
                to = TO_EN && (mcnt == TO - 1) && !s_ready && m_valid[mown];
                ev = m_valid[mown] && !to;
                er[mown] = s_ready || to;
                ee[mown] = (s_ready && s_error) || to;
            end
            chk("mdl s_valid", s_valid, ev);
            chk("mdl m_ready", m_ready, er);
            chk("mdl m_error", m_error, ee);
            if (ev) begin
                chk("mdl s_address", s_address, m_address[mown*40 +: 40]);
                chk("mdl s_rwCtrl", s_rwCtrl, m_rwCtrl[mown]);
                chk("mdl s_widthCtr", s_widthCtr, m_widthCtr[mown*2 +: 2]);
                chk("mdl s_writeBus", s_writeBus, m_writeBus[mown*64 +: 64]);
            end
            if (mbusy && s_ready) begin
                chk("mdl m_readBus", m_readBus, s_readBus);
            end
        end
        if (rst) begin
            mk    = 1'b1;
            mbusy = 1'b0;
            mptr  = 0;
        end else if (mk) begin
            if (mbusy) begin
                if (s_ready || !m_valid[mown] || to) begin
                    mbusy = 1'b0;
                    mptr  = (mown + 1) % 2;
                end else begin
                    mcnt++;
                end
            end else if (m_valid != 2'b00) begin
                mown  = m_valid[mptr] ? mptr : (1 - mptr);
                mbusy = 1'b1;
                mcnt  = 0;
            end
        end
    end

    initial begin
        rst        = 1'b1;
        m_valid    = 2'b11;
        m_address  = '0;
        m_rwCtrl   = '0;
        m_widthCtr = '0;
        m_writeBus = '0;
        s_readBus  = '0;
        s_ready    = 1'b0;
        s_error    = 1'b0;
        tick();
        @(negedge clk);
        chk("rst s_valid", s_valid, 1'b0);
        chk("rst m_ready", m_ready, 2'b00);
        chk("rst m_error", m_error, 2'b00);
        tick();
        rst     = 1'b0;
        m_valid = 2'b00;
        tick();

        // single read from requester 0
        setreq(0, A0, 1'b0, 2'd3, 64'h0);
        m_valid = 2'b01;
        @(negedge clk);
        chk("t1 idle s_valid", s_valid, 1'b0);
        tick();
        @(negedge clk);
        chk("t1 s_valid", s_valid, 1'b1);
        chk("t1 s_address", s_address, A0);
        chk("t1 s_widthCtr", s_widthCtr, 2'd3);
        chk("t1 wait m_ready", m_ready, 2'b00);
        tick();
        tick();
        @(negedge clk);
        chk("t1 hold s_valid", s_valid, 1'b1);
        tick();
        s_ready   = 1'b1;
        s_readBus = 64'hDEADBEEF_CAFEF00D;
        @(negedge clk);
        chk("t1 m_ready", m_ready, 2'b01);
        chk("t1 m_readBus", m_readBus, 64'hDEADBEEF_CAFEF00D);
        tick();
        m_valid = 2'b00;
        s_error = 1'b1;
        @(negedge clk);
        chk("t1 after s_valid", s_valid, 1'b0);
        chk("idle ready ign", m_ready, 2'b00);
        chk("idle error ign", m_error, 2'b00);
        tick();
        s_ready = 1'b0;
        s_error = 1'b0;

        // contention, pointer restarted by reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        setreq(1, A1, 1'b0, 2'd2, 64'h0);
        m_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("t2 gap s_valid", s_valid, 1'b0);
            tick();
            @(negedge clk);
            chk("t2 s_valid", s_valid, 1'b1);
            chk("t2 s_address", s_address, (t % 2 == 1) ? A1 : A0);
            tick();
            s_ready = 1'b1;
            @(negedge clk);
            chk("t2 m_ready", m_ready, (t % 2 == 1) ? 2'b10 : 2'b01);
            tick();
            s_ready = 1'b0;
        end
        m_valid = 2'b00;

        // write with error to requester 1
        setreq(1, A1, 1'b1, 2'd2, 64'h0123_4567_89AB_CDEF);
        m_valid = 2'b10;
        @(negedge clk);
        chk("t3 idle s_valid", s_valid, 1'b0);
        tick();
        s_ready = 1'b1;
        s_error = 1'b1;
        @(negedge clk);
        chk("t3 s_rwCtrl", s_rwCtrl, 1'b1);
        chk("t3 s_writeBus", s_writeBus, 64'h0123_4567_89AB_CDEF);
        chk("t3 m_ready", m_ready, 2'b10);
        chk("t3 m_error", m_error, 2'b10);
        tick();
        s_ready = 1'b0;
        s_error = 1'b0;
        m_valid = 2'b00;

        // abort by requester 0, requester 1 pending
        setreq(1, A1, 1'b0, 2'd3, 64'h0);
        m_valid = 2'b11;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("t4 s_address", s_address, A0);
        tick();
        @(negedge clk);
        chk("t4 busy2 s_valid", s_valid, 1'b1);
        tick();
        m_valid = 2'b10;
        @(negedge clk);
        chk("t4 abort s_valid", s_valid, 1'b0);
        chk("t4 abort m_ready", m_ready, 2'b00);
        tick();
        @(negedge clk);
        chk("t4 idle s_valid", s_valid, 1'b0);
        tick();
        s_ready = 1'b1;
        @(negedge clk);
        chk("t4 r1 s_valid", s_valid, 1'b1);
        chk("t4 r1 s_address", s_address, A1);
        chk("t4 r1 m_ready", m_ready, 2'b10);
        tick();
        s_ready = 1'b0;
        m_valid = 2'b00;

        // reset while requester 1 is granted
        m_valid = 2'b11;
        @(negedge clk);
        tick();
        s_ready = 1'b1;
        @(negedge clk);
        chk("t5 r0 m_ready", m_ready, 2'b01);
        tick();
        s_ready = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t5 busy s_address", s_address, A1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5 post s_valid", s_valid, 1'b0);
        chk("t5 post m_ready", m_ready, 2'b00);
        tick();
        s_ready = 1'b1;
        @(negedge clk);
        chk("t5 regrant addr", s_address, A0);
        chk("t5 regrant m_ready", m_ready, 2'b01);
        tick();
        s_ready = 1'b0;
        m_valid = 2'b00;

        // silent slave
        m_valid = 2'b01;
        @(negedge clk);
        for (int c = 1; c <= TO; c++) begin
            tick();
            @(negedge clk);
            if (c == TO) begin
                chk("t6 last s_valid", s_valid, TO_EN ? 1'b0 : 1'b1);
                chk("t6 last m_ready", m_ready, TO_EN ? 2'b01 : 2'b00);
                chk("t6 last m_error", m_error, TO_EN ? 2'b01 : 2'b00);
            end else if (c == 1 || c == TO - 1) begin
                chk("t6 wait s_valid", s_valid, 1'b1);
                chk("t6 wait m_ready", m_ready, 2'b00);
            end
        end
        tick();
        m_valid = 2'b00;
        @(negedge clk);
        chk("t6 end s_valid", s_valid, 1'b0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
